// File: rtl/ttl08_and.sv
// Cycle-based 74LS08 quad 2-input AND gate for the TTL Manchester Baby model.
// Propagation delay is DELAY_CYCLES clocks, either transport or inertial (glitch filtering).
module ttl08_and #(
    parameter int DELAY_CYCLES = 2,
    parameter int INERTIAL     = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A1,
    input  logic B1,
    output logic Y1,
    input  logic A2,
    input  logic B2,
    output logic Y2,
    input  logic A3,
    input  logic B3,
    output logic Y3,
    input  logic A4,
    input  logic B4,
    output logic Y4
);

    logic [3:0] a_vec;
    logic [3:0] b_vec;
    logic [3:0] r_vec;
    logic [3:0] y_vec;

    assign a_vec = {A4, A3, A2, A1};
    assign b_vec = {B4, B3, B2, B1};
    assign r_vec = a_vec & b_vec;
    assign {Y4, Y3, Y2, Y1} = y_vec;

    generate
        if (DELAY_CYCLES == 0) begin : g_comb
            assign y_vec = rst_n ? r_vec : 4'b0000;

        end else if (INERTIAL == 0) begin : g_transport
            for (genvar g = 0; g < 4; g++) begin : g_gate
                if (DELAY_CYCLES == 1) begin : g_one
                    logic y_q;

                    always_ff @(posedge clk) begin
                        if (!rst_n) begin
                            y_q <= 1'b0;
                        end else begin
                            y_q <= r_vec[g];
                        end
                    end

                    assign y_vec[g] = y_q;
                end else begin : g_multi
                    // Bit 0 is the newest sample; the MSB is the delayed output stage.
                    logic [DELAY_CYCLES-1:0] sh_q;

                    always_ff @(posedge clk) begin
                        if (!rst_n) begin
                            sh_q <= '0;
                        end else begin
                            sh_q <= {sh_q[DELAY_CYCLES-2:0], r_vec[g]};
                        end
                    end

                    assign y_vec[g] = sh_q[DELAY_CYCLES-1];
                end
            end

        end else begin : g_inertial
            localparam logic [3:0] N4 = 4'(DELAY_CYCLES);

            for (genvar g = 0; g < 4; g++) begin : g_gate
                logic       pend_q;
                logic       pend_nxt;
                logic [3:0] cnt_q;
                logic [3:0] cnt_nxt;
                logic       y_q;
                logic       y_nxt;

                // Output follows the next-state counter so steady latency matches transport mode.
                always_comb begin
                    pend_nxt = pend_q;
                    cnt_nxt  = cnt_q;
                    y_nxt    = y_q;
                    if (r_vec[g] != pend_q) begin
                        pend_nxt = r_vec[g];
                        cnt_nxt  = 4'd1;
                    end else if (cnt_q < N4) begin
                        cnt_nxt = cnt_q + 4'd1;
                    end
                    if ((cnt_nxt == N4) && (pend_nxt != y_q)) begin
                        y_nxt = pend_nxt;
                    end
                end

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        pend_q <= 1'b0;
                        cnt_q  <= 4'd0;
                        y_q    <= 1'b0;
                    end else begin
                        pend_q <= pend_nxt;
                        cnt_q  <= cnt_nxt;
                        y_q    <= y_nxt;
                    end
                end

                assign y_vec[g] = y_q;
            end
        end
    endgenerate

endmodule

// File: tb/tb_ttl08_and.sv
// Bench for ttl08_and: four instances (N=2, N=3 transport, N=3 inertial, N=0) share one
// stimulus stream; queue scoreboards and a run-length model supply expected outputs.
module tb_ttl08_and;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = 4'b0000;
    logic [3:0] b = 4'b0000;
    logic [3:0] y2;
    logic [3:0] y3;
    logic [3:0] yi;
    logic [3:0] y0;

    int n_checks = 0;
    int n_err    = 0;

    logic [3:0] exp2_q[$];
    logic [3:0] exp3_q[$];
    logic [3:0] expi_q[$];

    logic [3:0] run_val = 4'b0000;
    int         run_len[4];
    logic [3:0] yi_m = 4'b0000;

    always #5 clk = ~clk;

    ttl08_and #(.DELAY_CYCLES(2), .INERTIAL(0)) u_t2 (
        .clk(clk), .rst_n(rst_n),
        .A1(a[0]), .B1(b[0]), .Y1(y2[0]),
        .A2(a[1]), .B2(b[1]), .Y2(y2[1]),
        .A3(a[2]), .B3(b[2]), .Y3(y2[2]),
        .A4(a[3]), .B4(b[3]), .Y4(y2[3])
    );

    ttl08_and #(.DELAY_CYCLES(3), .INERTIAL(0)) u_t3 (
        .clk(clk), .rst_n(rst_n),
        .A1(a[0]), .B1(b[0]), .Y1(y3[0]),
        .A2(a[1]), .B2(b[1]), .Y2(y3[1]),
        .A3(a[2]), .B3(b[2]), .Y3(y3[2]),
        .A4(a[3]), .B4(b[3]), .Y4(y3[3])
    );

    ttl08_and #(.DELAY_CYCLES(3), .INERTIAL(1)) u_i3 (
        .clk(clk), .rst_n(rst_n),
        .A1(a[0]), .B1(b[0]), .Y1(yi[0]),
        .A2(a[1]), .B2(b[1]), .Y2(yi[1]),
        .A3(a[2]), .B3(b[2]), .Y3(yi[2]),
        .A4(a[3]), .B4(b[3]), .Y4(yi[3])
    );

    ttl08_and #(.DELAY_CYCLES(0), .INERTIAL(0)) u_c0 (
        .clk(clk), .rst_n(rst_n),
        .A1(a[0]), .B1(b[0]), .Y1(y0[0]),
        .A2(a[1]), .B2(b[1]), .Y2(y0[1]),
        .A3(a[2]), .B3(b[2]), .Y3(y0[2]),
        .A4(a[3]), .B4(b[3]), .Y4(y0[3])
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive inputs between edges; the N=0 instance must follow with no clock edge.
    task automatic drive(input logic r, input logic [3:0] na, input logic [3:0] nb);
        rst_n = r;
        a = na;
        b = nb;
        #1;
        check("comb_n0", y0, r ? (na & nb) : 4'b0000);
    endtask

    // One rising edge: update the expected streams from the sampled inputs, then compare.
    task automatic tick();
        logic [3:0] r;
        @(posedge clk);
        r = a & b;
        if (!rst_n) begin
            exp2_q.delete();
            exp3_q.delete();
            repeat (2) exp2_q.push_back(4'b0000);
            repeat (3) exp3_q.push_back(4'b0000);
        end else begin
            exp2_q.push_back(r);
            exp3_q.push_back(r);
        end
        for (int g = 0; g < 4; g++) begin
            if (!rst_n) begin
                run_val[g] = 1'b0;
                run_len[g] = 0;
                yi_m[g]    = 1'b0;
            end else begin
                if (r[g] !== run_val[g]) begin
                    run_val[g] = r[g];
                    run_len[g] = 1;
                end else begin
                    run_len[g] = run_len[g] + 1;
                end
                if (run_len[g] >= 3) yi_m[g] = run_val[g];
            end
        end
        expi_q.push_back(yi_m);
        #1;
        check("sb_t2", y2, exp2_q.pop_front());
        check("sb_t3", y3, exp3_q.pop_front());
        check("sb_i3", yi, expi_q.pop_front());
    endtask

    initial begin
        logic [3:0] m;
        for (int g = 0; g < 4; g++) run_len[g] = 0;

        // Reset
        drive(1'b0, 4'b0000, 4'b0000);
        repeat (2) tick();
        check("reset_t2", y2, 4'b0000);
        check("reset_t3", y3, 4'b0000);
        check("reset_i3", yi, 4'b0000);

        // Per gate truth table, others held at 00
        for (int g = 0; g < 4; g++) begin
            m = 4'b0001 << g;
            for (int p = 0; p < 4; p++) begin
                drive(1'b1, (p >= 2) ? m : 4'b0000, (p % 2 == 1) ? m : 4'b0000);
                repeat (5) tick();
                check("per_gate", y2, (p == 3) ? m : 4'b0000);
            end
        end

        // All gates at once: 11, 01, 10, 00
        drive(1'b1, 4'b0101, 4'b0011);
        tick();
        tick();
        check("all_gates", y2, 4'b0001);

        // Latency N=3 on gate 1, then a one-cycle pulse
        drive(1'b1, 4'b0001, 4'b0000);
        repeat (4) tick();
        drive(1'b1, 4'b0001, 4'b0001);
        tick();
        check("lat_k", y3, 4'b0000);
        tick();
        check("lat_k1", y3, 4'b0000);
        tick();
        check("lat_k2", y3, 4'b0001);
        drive(1'b1, 4'b0001, 4'b0000);
        repeat (4) tick();
        drive(1'b1, 4'b0001, 4'b0001);
        tick();
        drive(1'b1, 4'b0001, 4'b0000);
        tick();
        check("pulse_k1", y3, 4'b0000);
        tick();
        check("pulse_k2", y3, 4'b0001);
        tick();
        check("pulse_k3", y3, 4'b0000);
        check("pulse_inertial", yi, 4'b0000);

        // Reset mid-operation
        drive(1'b1, 4'b1111, 4'b1111);
        repeat (4) tick();
        check("pre_rst_t2", y2, 4'b1111);
        check("pre_rst_t3", y3, 4'b1111);
        drive(1'b0, 4'b1111, 4'b1111);
        tick();
        check("rst_t2", y2, 4'b0000);
        check("rst_t3", y3, 4'b0000);
        check("rst_i3", yi, 4'b0000);
        drive(1'b1, 4'b1111, 4'b1111);
        tick();
        check("post_rst1_t2", y2, 4'b0000);
        tick();
        check("post_rst2_t2", y2, 4'b1111);
        check("post_rst2_t3", y3, 4'b0000);
        tick();
        check("post_rst3_t3", y3, 4'b1111);
        check("post_rst3_i3", yi, 4'b1111);

        // Inertial: 2-cycle pulse is filtered, 4-cycle pulse passes
        drive(1'b1, 4'b0001, 4'b0000);
        repeat (5) tick();
        check("inert_idle", yi, 4'b0000);
        drive(1'b1, 4'b0001, 4'b0001);
        tick();
        check("inert_short1", yi, 4'b0000);
        tick();
        check("inert_short2", yi, 4'b0000);
        drive(1'b1, 4'b0001, 4'b0000);
        repeat (4) begin
            tick();
            check("inert_short_after", yi, 4'b0000);
        end
        drive(1'b1, 4'b0001, 4'b0001);
        tick();
        check("inert_long1", yi, 4'b0000);
        tick();
        check("inert_long2", yi, 4'b0000);
        tick();
        check("inert_long3", yi, 4'b0001);
        tick();
        check("inert_long4", yi, 4'b0001);
        drive(1'b1, 4'b0001, 4'b0000);
        repeat (4) tick();
        check("inert_release", yi, 4'b0000);

        // N=0: toggle with no clock edge, then reset forces zero immediately
        drive(1'b1, 4'b1111, 4'b1010);
        drive(1'b1, 4'b0110, 4'b1111);
        drive(1'b0, 4'b1111, 4'b1111);
        drive(1'b1, 4'b1111, 4'b1111);
        tick();

        // Random traffic with occasional reset
        repeat (60) begin
            drive(($urandom_range(0, 15) != 0), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
            repeat ($urandom_range(1, 4)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ttl08_and.md
Name: ttl08_and

Overview:
Cycle-based model of the 74LS08 quad 2-input AND gate, used as a drop-in component in the TTL-level Manchester Baby reconstruction. Each of four independent gates drives Y = A AND B. The chip's propagation delay is modelled as a configurable number of clock cycles, optionally with inertial (glitch-filtering) behaviour. Gates share only clock, reset and parameters.

Parameters:
- DELAY_CYCLES, 2, propagation delay in clk cycles; legal range 0..15. 0 = combinational output, gated only by reset.
- INERTIAL, 0, 0 = transport delay (every input change is reproduced, delayed); 1 = inertial delay (a result reaches Y only after it has been stable for DELAY_CYCLES consecutive cycles).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- A1  input  1  gate 1 input A
- B1  input  1  gate 1 input B
- Y1  output  1  gate 1 output
- A2  input  1  gate 2 input A
- B2  input  1  gate 2 input B
- Y2  output  1  gate 2 output
- A3  input  1  gate 3 input A
- B3  input  1  gate 3 input B
- Y3  output  1  gate 3 output
- A4  input  1  gate 4 input A
- B4  input  1  gate 4 input B
- Y4  output  1  gate 4 output

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Logic: each gate computes Yn = An AND Bn, independently of the other three gates.
- Reset:
  - rst_n sampled low at a rising edge clears all delay/filter state to 0.
  - Y1..Y4 = 0 from that edge, and remain 0 while rst_n stays low.
  - Reset asserted mid-operation discards all in-flight values.
  - After rst_n is sampled high, outputs stay 0 until the first post-reset result has traversed the full delay.
- DELAY_CYCLES = 0:
  - Yn = An & Bn combinationally while rst_n = 1.
  - Yn = 0 combinationally while rst_n = 0.
  - No registers in the data path.
- Transport mode (INERTIAL = 0, DELAY_CYCLES = N >= 1):
  - Per-gate shift register of depth N; stage 0 loads An & Bn each edge.
  - Yn = last stage, registered.
  - An input change sampled at edge k appears on Yn after edge k+N-1.
  - Latency is exactly N edges from the sampling edge, counting the sampling edge as the first.
  - A pulse of any width of 1 or more cycles is reproduced with the same width.
- Inertial mode (INERTIAL = 1, N >= 1):
  - Per-gate state: a pending value P, a stability counter C (4 bits), and an output register Yn.
  - Each edge, compute R = An & Bn.
  - If R != P: load P = R and set C = 1.
  - Else if C < N: increment C.
  - When C reaches N and P != Yn, load Yn = P.
  - A result that persists for fewer than N consecutive sampled cycles never reaches Yn.
  - Steady-state latency equals transport mode.
- Simultaneous changes on several gates are handled independently, with no cross-gate interaction.
- Inputs are treated as synchronous to clk; no synchronizers are included.
- Outputs are glitch-free registers for N >= 1.

Test Plan:
- Defaults (N = 2, transport), per gate 1..4: apply {A,B} = 00, 01, 10, 11, holding each for 5 cycles; Y samples 0, 0, 0, 1 respectively, and other gates' outputs are unaffected.
- All gates at once: A1B1 = 11, A2B2 = 01, A3B3 = 10, A4B4 = 00; after 2 edges Y1..Y4 = 1, 0, 0, 0.
- Latency: N = 3, A1 = 1, then B1 rises before edge k; Y1 = 0 after edges k and k+1, and Y1 = 1 after edge k+2. A 1-cycle B1 pulse produces a 1-cycle Y1 pulse.
- Reset mid-operation: with Y1..Y4 = 1 and all inputs 11, drive rst_n = 0 for one edge; all Y = 0 on that edge, then return to 1 N edges after rst_n is sampled high.
- Inertial: N = 3, INERTIAL = 1, starting from Y1 = 0.
  - A B1 pulse lasting 2 cycles leaves Y1 at 0 throughout.
  - A B1 pulse lasting 4 cycles gives Y1 = 1 starting 3 edges after the rise.
- N = 0: toggling the inputs changes Y combinationally with no clock edge; rst_n = 0 forces all Y = 0 immediately.
